// File: rtl/one_shot_tx_responder.sv
// -----------------------------------------------------------------------------
// one_shot_tx_responder
//
// Responder end of the one-shot launch/release handshake. A single-cycle
// launch pulse (i_start) captures i_data and sends it on o_tx as an 8N1-style
// frame: one start bit (0), DATA_WIDTH data bits LSB first, and one stop bit (1).
// Each bit lasts CLKS_PER_BIT cycles. A single RELEASE cycle follows the stop
// bit. In that cycle o_release pulses, which re-arms the launching one-shot.
//
// Ports
//   i_clk      system clock, rising edge
//   i_rst_n    asynchronous active-low reset
//   i_en       global enable; low freezes the frame and suppresses o_release
//   i_start    launch pulse, accepted only while idle
//   i_data     payload, captured on an accepted launch
//   i_ovr_clr  clears the sticky overrun flag
//   o_tx       serial line, idles high
//   o_busy     frame in progress (including the release cycle)
//   o_release  one-cycle pulse at frame end
//   o_overrun  sticky: launch seen while a frame was in flight
// -----------------------------------------------------------------------------
module one_shot_tx_responder #(
   parameter int DATA_WIDTH   = 8,
   parameter int CLKS_PER_BIT = 434
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_en,
   input  logic                  i_start,
   input  logic [DATA_WIDTH-1:0] i_data,
   input  logic                  i_ovr_clr,
   output logic                  o_tx,
   output logic                  o_busy,
   output logic                  o_release,
   output logic                  o_overrun
);

   localparam int BAUD_W = $clog2(CLKS_PER_BIT);
   localparam int BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_START   = 3'd1,
      S_DATA    = 3'd2,
      S_STOP    = 3'd3,
      S_RELEASE = 3'd4
   } state_t;

   state_t                state_q,   state_d;
   logic [BAUD_W-1:0]     baud_cnt_q, baud_cnt_d;
   logic [BIT_W-1:0]      bit_cnt_q,  bit_cnt_d;
   logic [DATA_WIDTH-1:0] shift_q,    shift_d;
   logic                  tx_q,       tx_d;
   logic                  busy_q,     busy_d;
   logic                  release_q,  release_d;
   logic                  overrun_q,  overrun_d;

   logic baud_done_s;
   logic last_bit_s;

   assign baud_done_s = (baud_cnt_q == BAUD_W'(CLKS_PER_BIT - 1));
   assign last_bit_s  = (bit_cnt_q  == BIT_W'(DATA_WIDTH - 1));

   // State, counters, shift register and registered outputs.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= S_IDLE;
         baud_cnt_q <= {BAUD_W{1'b0}};
         bit_cnt_q  <= {BIT_W{1'b0}};
         shift_q    <= {DATA_WIDTH{1'b0}};
         tx_q       <= 1'b1;
         busy_q     <= 1'b0;
         release_q  <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         baud_cnt_q <= baud_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         tx_q       <= tx_d;
         busy_q     <= busy_d;
         release_q  <= release_d;
         overrun_q  <= overrun_d;
      end
   end

   // Next-state logic. Outputs are decoded from the next state so that they
   // are registered and line up with the state they describe.
   always_comb begin
      state_d    = state_q;
      baud_cnt_d = baud_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      tx_d       = tx_q;
      busy_d     = busy_q;
      release_d  = release_q;
      overrun_d  = overrun_q;

      if (i_en) begin
         case (state_q)
            S_IDLE: begin
               if (i_start) begin
                  state_d    = S_START;
                  shift_d    = i_data;
                  baud_cnt_d = {BAUD_W{1'b0}};
                  bit_cnt_d  = {BIT_W{1'b0}};
               end else begin
                  state_d    = S_IDLE;
               end
            end
            S_START: begin
               if (baud_done_s) begin
                  state_d    = S_DATA;
                  baud_cnt_d = {BAUD_W{1'b0}};
               end else begin
                  baud_cnt_d = baud_cnt_q + BAUD_W'(1);
               end
            end
            S_DATA: begin
               if (baud_done_s) begin
                  baud_cnt_d = {BAUD_W{1'b0}};
                  shift_d    = shift_q >> 1;
                  if (last_bit_s) begin
                     state_d = S_STOP;
                  end else begin
                     bit_cnt_d = bit_cnt_q + BIT_W'(1);
                  end
               end else begin
                  baud_cnt_d = baud_cnt_q + BAUD_W'(1);
               end
            end
            S_STOP: begin
               if (baud_done_s) begin
                  state_d    = S_RELEASE;
                  baud_cnt_d = {BAUD_W{1'b0}};
               end else begin
                  baud_cnt_d = baud_cnt_q + BAUD_W'(1);
               end
            end
            S_RELEASE: begin
               state_d = S_IDLE;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase

         case (state_d)
            S_IDLE: begin
               tx_d      = 1'b1;
               busy_d    = 1'b0;
               release_d = 1'b0;
            end
            S_START: begin
               tx_d      = 1'b0;
               busy_d    = 1'b1;
               release_d = 1'b0;
            end
            S_DATA: begin
               tx_d      = shift_d[0];
               busy_d    = 1'b1;
               release_d = 1'b0;
            end
            S_STOP: begin
               tx_d      = 1'b1;
               busy_d    = 1'b1;
               release_d = 1'b0;
            end
            S_RELEASE: begin
               tx_d      = 1'b1;
               busy_d    = 1'b1;
               release_d = 1'b1;
            end
            default: begin
               tx_d      = 1'b1;
               busy_d    = 1'b0;
               release_d = 1'b0;
            end
         endcase

         // A launch outside IDLE is dropped; set beats clear.
         if (i_start && (state_q != S_IDLE)) begin
            overrun_d = 1'b1;
         end else if (i_ovr_clr) begin
            overrun_d = 1'b0;
         end else begin
            overrun_d = overrun_q;
         end
      end else begin
         state_d = state_q;
      end
   end

   assign o_tx      = tx_q;
   assign o_busy    = busy_q;
   // The release pulse is masked while frozen; the RELEASE state is held until
   // i_en returns. The pulse therefore coincides with the cycle that completes.
   assign o_release = release_q & i_en;
   assign o_overrun = overrun_q;

endmodule

// File: tb/tb_one_shot_tx_responder.sv
// -----------------------------------------------------------------------------
// tb_one_shot_tx_responder
//
// Testbench for one_shot_tx_responder with CLKS_PER_BIT=4 and DATA_WIDTH=8.
// A behavioural model tracks the position of the frame in enabled cycles
// since launch, and every output is derived from that position. A compare
// process checks the DUT against the model on each falling edge. Directed
// scenarios pin the expected waveform with literal values. A randomized
// phase follows.
// -----------------------------------------------------------------------------
module tb_one_shot_tx_responder;

   localparam int C  = 4;
   localparam int W  = 8;
   localparam int FR = (W + 2) * C + 1;   // frame position of the release cycle
   localparam int HN = 8192;

   logic         clk;
   logic         i_rst_n;
   logic         i_en;
   logic         i_start;
   logic [W-1:0] i_data;
   logic         i_ovr_clr;
   logic         o_tx;
   logic         o_busy;
   logic         o_release;
   logic         o_overrun;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   // model state
   int           m_pos;
   logic [W-1:0] m_data;
   logic         m_ovr;

   logic tx_hist   [0:HN-1];
   logic busy_hist [0:HN-1];
   logic rel_hist  [0:HN-1];

   one_shot_tx_responder #(
      .DATA_WIDTH   (W),
      .CLKS_PER_BIT (C)
   ) dut (
      .i_clk     (clk),
      .i_rst_n   (i_rst_n),
      .i_en      (i_en),
      .i_start   (i_start),
      .i_data    (i_data),
      .i_ovr_clr (i_ovr_clr),
      .o_tx      (o_tx),
      .o_busy    (o_busy),
      .o_release (o_release),
      .o_overrun (o_overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // cycle counter
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         failures = failures + 1;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   // Reference model: the frame is a count of enabled cycles since launch.
   always @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         m_pos <= 0;
         m_ovr <= 1'b0;
      end else if (i_en) begin
         if (m_pos == 0) begin
            if (i_start) begin
               m_pos  <= 1;
               m_data <= i_data;
            end
         end else if (m_pos == FR) begin
            m_pos <= 0;
         end else begin
            m_pos <= m_pos + 1;
         end
         if (i_start && m_pos != 0) m_ovr <= 1'b1;
         else if (i_ovr_clr)        m_ovr <= 1'b0;
      end
   end

   // Compare DUT against model on every falling edge and record history.
   always @(negedge clk) begin
      logic e_tx, e_busy, e_rel;
      if (m_pos == 0) begin
         e_tx = 1'b1; e_busy = 1'b0; e_rel = 1'b0;
      end else if (m_pos <= C) begin
         e_tx = 1'b0; e_busy = 1'b1; e_rel = 1'b0;
      end else if (m_pos <= (W + 1) * C) begin
         e_tx = m_data[(m_pos - C - 1) / C]; e_busy = 1'b1; e_rel = 1'b0;
      end else if (m_pos <= (W + 2) * C) begin
         e_tx = 1'b1; e_busy = 1'b1; e_rel = 1'b0;
      end else begin
         e_tx = 1'b1; e_busy = 1'b1; e_rel = i_en;
      end
      chk("model_tx",      o_tx,      e_tx);
      chk("model_busy",    o_busy,    e_busy);
      chk("model_release", o_release, e_rel);
      chk("model_overrun", o_overrun, m_ovr);
      if (cyc < HN) begin
         tx_hist[cyc]   = o_tx;
         busy_hist[cyc] = o_busy;
         rel_hist[cyc]  = o_release;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_to(input int c);
      while (cyc < c) tick();
   endtask

   task automatic launch(input logic [W-1:0] d, output int s);
      i_start = 1'b1;
      i_data  = d;
      s       = cyc;
      tick();
      i_start = 1'b0;
   endtask

   task automatic chk_frame(input int s, input logic [W-1:0] d);
      for (int b = 0; b < W + 2; b++) begin
         logic e;
         if (b == 0)          e = 1'b0;
         else if (b == W + 1) e = 1'b1;
         else                 e = d[b-1];
         chk("frame_bit", tx_hist[s + 2 + C * b], e);
      end
   endtask

   initial begin
      int s;
      int s2;
      logic [9:0] pat_a5;
      pat_a5    = 10'b1101001010;
      i_rst_n   = 1'b0;
      i_en      = 1'b1;
      i_start   = 1'b0;
      i_data    = 8'h00;
      i_ovr_clr = 1'b0;
      repeat (3) tick();
      i_rst_n = 1'b1;

      // idle after reset
      repeat (10) tick();
      chk("idle_tx",      o_tx,      1'b1);
      chk("idle_busy",    o_busy,    1'b0);
      chk("idle_release", o_release, 1'b0);
      chk("idle_overrun", o_overrun, 1'b0);

      // A5 frame, literal line pattern and timing
      launch(8'hA5, s);
      wait_to(s + 45);
      for (int b = 0; b < 10; b++) chk("a5_bit", tx_hist[s + 2 + C * b], pat_a5[b]);
      chk("a5_tx_fall", tx_hist[s + 1], 1'b0);
      chk("a5_rel40",  rel_hist[s + 40],  1'b0);
      chk("a5_rel41",  rel_hist[s + 41],  1'b1);
      chk("a5_rel42",  rel_hist[s + 42],  1'b0);
      chk("a5_busy41", busy_hist[s + 41], 1'b1);
      chk("a5_busy42", busy_hist[s + 42], 1'b0);

      // overrun during 3C frame
      launch(8'h3C, s);
      wait_to(s + 10);
      i_start = 1'b1;
      i_data  = 8'hFF;
      tick();
      i_start = 1'b0;
      wait_to(s + 45);
      chk_frame(s, 8'h3C);
      chk("ovr_rel41", rel_hist[s + 41], 1'b1);
      chk("ovr_set", o_overrun, 1'b1);
      i_ovr_clr = 1'b1;
      tick();
      i_ovr_clr = 1'b0;
      chk("ovr_clr", o_overrun, 1'b0);

      // enable freeze mid-DATA
      launch(8'hA5, s);
      wait_to(s + 15);
      i_en = 1'b0;
      repeat (7) tick();
      i_en = 1'b1;
      wait_to(s + 52);
      chk("frz_tx", tx_hist[s + 22], 1'b1);
      chk("frz_rel41", rel_hist[s + 41], 1'b0);
      chk("frz_rel48", rel_hist[s + 48], 1'b1);
      chk("frz_busy49", busy_hist[s + 49], 1'b0);

      // reset mid-frame
      launch(8'hFF, s);
      wait_to(s + 20);
      i_rst_n = 1'b0;
      #1;
      chk("rst_tx",   o_tx,   1'b1);
      chk("rst_busy", o_busy, 1'b0);
      tick();
      tick();
      i_rst_n = 1'b1;
      tick();
      launch(8'h00, s);
      wait_to(s + 45);
      chk_frame(s, 8'h00);
      chk("rst_rel41", rel_hist[s + 41], 1'b1);

      // launch in RELEASE cycle is dropped
      launch(8'h5A, s);
      wait_to(s + 41);
      i_start = 1'b1;
      i_data  = 8'h77;
      tick();
      i_start = 1'b0;
      wait_to(s + 45);
      chk("relst_rel41", rel_hist[s + 41], 1'b1);
      chk("relst_busy43", busy_hist[s + 43], 1'b0);
      chk("relst_ovr", o_overrun, 1'b1);
      i_ovr_clr = 1'b1;
      tick();
      i_ovr_clr = 1'b0;

      // launch one cycle after RELEASE is accepted
      launch(8'h81, s);
      wait_to(s + 42);
      launch(8'hC3, s2);
      wait_to(s2 + 45);
      chk("post_busy", busy_hist[s2 + 1], 1'b1);
      chk_frame(s2, 8'hC3);
      chk("post_rel41", rel_hist[s2 + 41], 1'b1);
      chk("post_ovr", o_overrun, 1'b0);

      // randomized phase
      for (int i = 0; i < 3000; i++) begin
         i_en      = ($urandom % 8) != 0;
         i_start   = ($urandom % 12) == 0;
         i_ovr_clr = ($urandom % 16) == 0;
         i_data    = W'($urandom);
         if (($urandom % 700) == 0) begin
            i_rst_n = 1'b0;
            tick();
            i_rst_n = 1'b1;
         end else begin
            tick();
         end
      end
      i_start   = 1'b0;
      i_ovr_clr = 1'b0;
      i_en      = 1'b1;
      repeat (3) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
